// File: rtl/sys_pkg.sv
// Shared mode and state encodings for the LED monitor.
package sys_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_FREEZE = 2'b10;

  typedef enum logic [1:0] {
    ST_DIRECT = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FREEZE = 2'd2
  } state_e;

  // Reserved mode 2'b11 falls back to DIRECT.
  function automatic state_e decode_mode(input logic [1:0] mode);
    case (mode)
      MODE_SCAN:   return ST_SCAN;
      MODE_FREEZE: return ST_FREEZE;
      default:     return ST_DIRECT;
    endcase
  endfunction

endpackage

// File: rtl/sys_clk_div.sv
// Free-running divider; tick is the combinational terminal-count condition
// (div_cnt == DIVISOR-1), constantly high when DIVISOR is 1.
module sys_clk_div #(
  parameter int unsigned DIVISOR = 1
) (
  input  logic clk,
  input  logic SYS_reset_n,
  output logic tick
);

  localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;

  assign tick      = (div_cnt_q == LAST);
  assign div_cnt_d = tick ? '0 : div_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) div_cnt_q <= '0;
    else              div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/sys_led_monitor.sv
// Multi-channel LED monitor: direct channel select, timed scan across
// channels, or display of a frozen snapshot of all channels.
module sys_led_monitor
  import sys_pkg::*;
#(
  parameter int unsigned DIVISOR  = 1,
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned CH_WIDTH = 27,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         SYS_reset_n,
  input  logic [SEL_W-1:0]             SYS_output_sel,
  input  logic [1:0]                   SYS_mode,
  input  logic [NUM_CH*CH_WIDTH-1:0]   SYS_ch_data,
  output logic [CH_WIDTH-1:0]          SYS_leds,
  output logic                         SYS_tick,
  output logic [SEL_W-1:0]             SYS_cur_ch
);

  state_e                     state_q, state_d;
  logic [SEL_W-1:0]           cur_ch_q, cur_ch_d;
  logic [CH_WIDTH-1:0]        leds_q, leds_d;
  logic [NUM_CH*CH_WIDTH-1:0] snap_q, snap_d;
  logic                       tick_q;
  logic                       tc;
  logic [SEL_W-1:0]           scan_ch;

  sys_clk_div #(.DIVISOR(DIVISOR)) u_clk_div (
    .clk         (clk),
    .SYS_reset_n (SYS_reset_n),
    .tick        (tc)
  );

  // Indices with no matching channel (non-power-of-two NUM_CH) select zero.
  function automatic logic [CH_WIDTH-1:0] pick(input logic [NUM_CH*CH_WIDTH-1:0] bank,
                                               input logic [SEL_W-1:0] idx);
    logic [CH_WIDTH-1:0] val;
    val = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (idx == SEL_W'(i)) val = bank[i*CH_WIDTH +: CH_WIDTH];
    end
    return val;
  endfunction

  // A scan entered from an out-of-range direct select restarts at channel 0.
  always_comb begin
    scan_ch = cur_ch_q;
    if (tc) begin
      if (cur_ch_q >= SEL_W'(NUM_CH - 1)) scan_ch = '0;
      else                               scan_ch = cur_ch_q + SEL_W'(1);
    end
  end

  always_comb begin
    state_d  = decode_mode(SYS_mode);
    cur_ch_d = cur_ch_q;
    leds_d   = leds_q;
    snap_d   = snap_q;
    case (state_d)
      ST_SCAN: begin
        cur_ch_d = scan_ch;
        leds_d   = pick(SYS_ch_data, scan_ch);
      end
      ST_FREEZE: begin
        cur_ch_d = SYS_output_sel;
        if (state_q != ST_FREEZE) begin
          snap_d = SYS_ch_data;
          leds_d = pick(SYS_ch_data, SYS_output_sel);
        end else begin
          leds_d = pick(snap_q, SYS_output_sel);
        end
      end
      default: begin
        cur_ch_d = SYS_output_sel;
        leds_d   = pick(SYS_ch_data, SYS_output_sel);
      end
    endcase
  end

  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      state_q  <= ST_DIRECT;
      cur_ch_q <= '0;
      leds_q   <= '0;
      snap_q   <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      leds_q   <= leds_d;
      snap_q   <= snap_d;
      tick_q   <= tc;
    end
  end

  assign SYS_leds   = leds_q;
  assign SYS_tick   = tick_q;
  assign SYS_cur_ch = cur_ch_q;

endmodule

// File: doc/sys_led_monitor.md
SYS_LED_MONITOR -- requirements
Module: sys_led_monitor

Interface
REQ-001 SHALL have parameter DIVISOR, default 1: clock-enable period in clk cycles, legal range 1..2^24.
REQ-002 SHALL have parameter NUM_CH, default 8: number of monitored channels, legal range 2..16.
REQ-003 SHALL have parameter CH_WIDTH, default 27: width of each channel and of the LED bus.
REQ-004 SHALL have derived localparam SEL_W = clog2(NUM_CH).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port SYS_reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port SYS_output_sel, input, SEL_W bits: channel select used in DIRECT and FREEZE.
REQ-008 SHALL have port SYS_mode, input, 2 bits: 00 DIRECT, 01 SCAN, 10 FREEZE, 11 reserved and treated as DIRECT.
REQ-009 SHALL have port SYS_ch_data, input, NUM_CH*CH_WIDTH bits: channel i occupies bits [i*CH_WIDTH +: CH_WIDTH].
REQ-010 SHALL have port SYS_leds, output, CH_WIDTH bits: registered display value.
REQ-011 SHALL have port SYS_tick, output, 1 bit: one-cycle step-enable pulse, registered.
REQ-012 SHALL have port SYS_cur_ch, output, SEL_W bits: the channel currently driving SYS_leds, registered.

Function
REQ-013 SHALL implement divider counter div_cnt, 0..DIVISOR-1, incrementing every cycle and wrapping to 0 after DIVISOR-1.
REQ-014 SHALL assert SYS_tick for exactly the one cycle after each cycle in which div_cnt == DIVISOR-1.
REQ-015 SHALL hold SYS_tick high continuously after reset when DIVISOR = 1, starting from the first clock edge.
REQ-016 SHALL implement an FSM with states DIRECT, SCAN and FREEZE; the next state equals the decode of SYS_mode sampled on each edge.
REQ-017 SHALL, in DIRECT: cur_ch <= SYS_output_sel and SYS_leds <= channel[SYS_output_sel], with 1-cycle latency from input to output.
REQ-018 SHALL, in SCAN: increment cur_ch on each cycle in which the internal tick condition (div_cnt == DIVISOR-1) holds, wrapping NUM_CH-1 -> 0.
REQ-019 SHALL, in SCAN: drive SYS_leds <= channel[cur_ch next value], so the LEDs and SYS_cur_ch change on the same edge.
REQ-020 SHALL, on the transition into SCAN: start scanning from the current cur_ch and leave div_cnt unaffected.
REQ-021 SHALL, on the edge that transitions into FREEZE from another state: capture all NUM_CH channels into the snapshot registers.
REQ-022 SHALL, in FREEZE: drive SYS_leds <= snapshot[SYS_output_sel] and ignore live SYS_ch_data changes.
REQ-023 SHALL, while remaining in FREEZE: not recapture the snapshot; leaving and re-entering FREEZE recaptures it.
REQ-024 SHALL, whenever SYS_output_sel >= NUM_CH (non-power-of-two NUM_CH) in DIRECT or FREEZE: drive SYS_leds to 0 and SYS_cur_ch to SYS_output_sel.
REQ-025 SHALL, when a mode change and the tick condition coincide: let the new mode win; a scan increment occurs only if the new state is SCAN.
REQ-026 SHALL keep the divider running in every mode; SYS_tick is mode-independent.

Reset
REQ-027 SHALL, while SYS_reset_n = 0, immediately clear div_cnt to 0, SYS_tick to 0, cur_ch to 0, SYS_leds to 0, all snapshots to 0, and set the state to DIRECT.
REQ-028 SHALL, on the first rising clk edge after SYS_reset_n deasserts, behave as DIRECT with div_cnt = 0.
REQ-029 SHALL, on reset asserted mid-scan or mid-freeze, discard the scan position and snapshot contents with no residual state.

Structure
REQ-030 SHALL place the mode encodings (MODE_DIRECT, MODE_SCAN, MODE_FREEZE) and the FSM state encodings in the shared package sys_pkg.
REQ-031 SHALL implement the divider as sub-module sys_clk_div (parameter DIVISOR; ports clk, SYS_reset_n, tick), instantiated once.
REQ-032 SHALL keep the channel mux, snapshot bank and FSM in sys_led_monitor, in the 120-400 line range.

Verification
REQ-033 SHALL cover: DIVISOR=4, reset then run 20 cycles -> SYS_tick high on cycles 4, 8, 12, 16, 20 only.
REQ-034 SHALL cover: DIRECT, sel=3, ch3=27'h1234567 -> SYS_leds=27'h1234567 and SYS_cur_ch=3 one cycle later; changing sel to 5 updates the LEDs one cycle later.
REQ-035 SHALL cover: SCAN, DIVISOR=2, NUM_CH=8 -> SYS_cur_ch sequences 1,2,...,7,0,1 changing every 2 cycles, with SYS_leds matching each channel.
REQ-036 SHALL cover: FREEZE with ch2=27'h0AA, then ch2 changed to 27'h055 -> SYS_leds stays 27'h0AA; exit to DIRECT and re-enter FREEZE -> 27'h055.
REQ-037 SHALL cover: NUM_CH=5, DIRECT, sel=6 -> SYS_leds=0, SYS_cur_ch=6.
REQ-038 SHALL cover: SYS_reset_n pulsed low between edges mid-SCAN at cur_ch=4 -> all outputs 0 before the next edge; after release the block is in DIRECT with div_cnt=0.
